// File: rtl/lbist_pkg.sv
// Shared types and constants for the LBIST controller and its ALU CUT.
// Holds FSM states, RV32I ALU op codes and the LFSR/MISR tap positions.
package lbist_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CMP,
    S_DONE
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  localparam int TAP0 = 31;
  localparam int TAP1 = 21;
  localparam int TAP2 = 1;
  localparam int TAP3 = 0;

  // One step of the shared shift/feedback used by LFSR and MISR.
  function automatic logic [31:0] fb_shift(
    input logic [31:0] v
  );
    return {v[30:0], v[TAP0] ^ v[TAP1] ^ v[TAP2] ^ v[TAP3]};
  endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational RV32I ALU used as the circuit under test.
// Ports: a, b operands; op = {funct7[5], funct3}; y result.
module rv_alu
  import lbist_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] y
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    y = a + b;
    unique case (op)
      OP_SUB:  y = a - b;
      OP_SLL:  y = a << shamt;
      OP_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: y = {31'b0, a < b};
      OP_XOR:  y = a ^ b;
      OP_SRL:  y = a >> shamt;
      OP_SRA:  y = 32'($signed(a) >>> shamt);
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/lbist_risc_v.sv
// LBIST controller: LFSR patterns into rv_alu, MISR compaction, golden compare.
// Ports: clk, nRst (async low), test_start in; test_done, P_F (1=pass) out.
module lbist_risc_v
  import lbist_pkg::*;
#(
  parameter int          N_PATTERNS   = 32,
  parameter logic [31:0] LFSR_SEED    = 32'h0000_0001,
  parameter logic [31:0] GOLDEN_SIG   = 32'h0000_0000,
  parameter bit          FAULT_INJECT = 1'b0
) (
  input  logic clk,
  input  logic nRst,
  input  logic test_start,
  output logic test_done,
  output logic P_F
);

  localparam logic [15:0] LAST = 16'(N_PATTERNS - 1);

  state_e      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] misr_q, misr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pf_q, pf_d;
  logic        done_q, done_d;

  logic [31:0] alu_b;
  logic [31:0] alu_raw;
  logic [31:0] alu_y;

  assign alu_b = {lfsr_q[15:0], lfsr_q[31:16]};

  rv_alu u_alu (
    .a  (lfsr_q),
    .b  (alu_b),
    .op (lfsr_q[3:0]),
    .y  (alu_raw)
  );

  assign alu_y = {alu_raw[31:1], alu_raw[0] & ~FAULT_INJECT};

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pf_d    = pf_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (test_start) begin
          lfsr_d  = LFSR_SEED;
          misr_d  = '0;
          cnt_d   = '0;
          pf_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        misr_d = fb_shift(misr_q) ^ alu_y;
        lfsr_d = fb_shift(lfsr_q);
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == LAST) state_d = S_CMP;
      end
      S_CMP: begin
        pf_d    = (misr_q == GOLDEN_SIG);
        state_d = S_DONE;
      end
      S_DONE: begin
        // First DONE cycle raises test_done; leaving is only
        // possible once it has been visible for a cycle.
        if (!done_q) begin
          done_d = 1'b1;
        end else if (!test_start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      pf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      pf_q    <= pf_d;
      done_q  <= done_d;
    end
  end

  assign test_done = done_q;
  assign P_F       = pf_q;

endmodule

// File: tb/tb_lbist_risc_v.sv
// Scoreboard bench for lbist_risc_v: four instances (pass, fail, fault, short).
// Expected done time and pass/fail come from a behavioural signature model.
module tb_lbist_risc_v;

  function automatic logic [31:0] ref_alu(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op
  );
    int unsigned sh;
    sh = int'(b % 32);
    case (op)
      4'd8:    return a - b;
      4'd1:    return a << sh;
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd5:    return a >> sh;
      4'd13:   return 32'($signed(a) >>> sh);
      4'd6:    return a | b;
      4'd7:    return a & b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] model_sig(
    input int          n,
    input logic [31:0] seed,
    input bit          fi
  );
    logic [31:0] r, m, y, b, mask;
    mask = 32'h8020_0003;
    r = seed;
    m = 32'h0;
    for (int i = 0; i < n; i++) begin
      b = (r << 16) | (r >> 16);
      y = ref_alu(r, b, r[3:0]);
      if (fi) y = y & ~32'h1;
      m = ((m << 1) | {31'b0, ^(m & mask)}) ^ y;
      r = (r << 1) | {31'b0, ^(r & mask)};
    end
    return m;
  endfunction

  localparam logic [31:0] SEED_S = 32'hACE1_2345;
  localparam logic [31:0] GOLD   = model_sig(32, 32'h1, 1'b0);
  localparam logic [31:0] GOLD_S = model_sig(2, SEED_S, 1'b0);
  localparam logic [31:0] SIG_F  = model_sig(32, 32'h1, 1'b1);

  localparam int LAT [4] = '{34, 34, 34, 4};
  localparam bit EPF [4] = '{
    1'b1,
    1'b0,
    (SIG_F == GOLD),
    1'b1
  };

  logic       clk;
  logic       nRst;
  logic       test_start;
  logic [3:0] done_v;
  logic [3:0] pf_v;

  lbist_risc_v #(
    .N_PATTERNS(32), .LFSR_SEED(32'h1),
    .GOLDEN_SIG(GOLD), .FAULT_INJECT(1'b0)
  ) u_pass (
    .clk(clk), .nRst(nRst), .test_start(test_start),
    .test_done(done_v[0]), .P_F(pf_v[0])
  );

  lbist_risc_v #(
    .N_PATTERNS(32), .LFSR_SEED(32'h1),
    .GOLDEN_SIG(GOLD ^ 32'h1), .FAULT_INJECT(1'b0)
  ) u_fail (
    .clk(clk), .nRst(nRst), .test_start(test_start),
    .test_done(done_v[1]), .P_F(pf_v[1])
  );

  lbist_risc_v #(
    .N_PATTERNS(32), .LFSR_SEED(32'h1),
    .GOLDEN_SIG(GOLD), .FAULT_INJECT(1'b1)
  ) u_fault (
    .clk(clk), .nRst(nRst), .test_start(test_start),
    .test_done(done_v[2]), .P_F(pf_v[2])
  );

  lbist_risc_v #(
    .N_PATTERNS(2), .LFSR_SEED(SEED_S),
    .GOLDEN_SIG(GOLD_S), .FAULT_INJECT(1'b0)
  ) u_short (
    .clk(clk), .nRst(nRst), .test_start(test_start),
    .test_done(done_v[3]), .P_F(pf_v[3])
  );

  typedef struct {
    int unsigned cyc;
    logic        pf;
  } exp_t;

  exp_t        sb [4][$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  prev = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  // Monitor: pop on each rising test_done, flag overdue entries.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (done_v[i] && !prev[i]) begin
        if (sb[i].size() == 0) begin
          check($sformatf("unexpected_done[%0d]", i), 1, 0);
        end else begin
          e = sb[i].pop_front();
          check($sformatf("done_cycle[%0d]", i), cyc, e.cyc);
          check($sformatf("pass_fail[%0d]", i), {31'b0, pf_v[i]},
                {31'b0, e.pf});
        end
      end else if (sb[i].size() > 0 && sb[i][0].cyc < cyc) begin
        check($sformatf("done_timeout[%0d]", i), 0, 1);
        void'(sb[i].pop_front());
      end
    end
    prev = done_v;
  end

  task automatic check_zero(input string nm);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_done[%0d]", nm, i), {31'b0, done_v[i]}, 0);
      check($sformatf("%s_pf[%0d]", nm, i), {31'b0, pf_v[i]}, 0);
    end
  endtask

  task automatic start_run();
    exp_t e;
    @(negedge clk);
    #2;
    test_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e.cyc = cyc + 1 + LAT[i];
      e.pf  = EPF[i];
      sb[i].push_back(e);
    end
  endtask

  task automatic finish_and_drop();
    repeat (35 + $urandom_range(0, 4)) @(negedge clk);
    #2;
    test_start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("rearm_fall[%0d]", i), {31'b0, done_v[i]}, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic normal_run();
    start_run();
    finish_and_drop();
    start_run();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("rerun_pf_clear[%0d]", i), {31'b0, pf_v[i]}, 0);
    repeat (32) @(negedge clk);
    #2;
    test_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic middrop_run();
    start_run();
    repeat (11) @(negedge clk);
    #2;
    test_start = 1'b0;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("middrop_idle[%0d]", i), {31'b0, done_v[i]}, 0);
  endtask

  task automatic reset_run();
    start_run();
    repeat (16) @(negedge clk);
    #2;
    nRst = 1'b0;
    test_start = 1'b0;
    #1;
    check_zero("midreset");
    for (int i = 0; i < 4; i++) sb[i].delete();
    @(negedge clk);
    #2;
    nRst = 1'b1;
    normal_run();
  endtask

  initial begin
    nRst = 1'b0;
    test_start = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_hold");
    #2;
    nRst = 1'b1;
    repeat (10) @(negedge clk);
    check_zero("idle_hold");

    normal_run();
    middrop_run();
    reset_run();
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      case ($urandom_range(0, 2))
        0: normal_run();
        1: middrop_run();
        default: reset_run();
      endcase
    end

    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("sb_drain[%0d]", i), sb[i].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
